// File: rtl/seq_pkg.sv
// Shared types and default sizes for the instruction sequencer.
package seq_pkg;

    localparam int unsigned PC_W_DEF      = 12;
    localparam int unsigned RAS_DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF     = 16;

    typedef enum logic [2:0] {
        OP_SEQ     = 3'd0,
        OP_BR_COND = 3'd1,
        OP_JUMP    = 3'd2,
        OP_CALL    = 3'd3,
        OP_RET     = 3'd4,
        OP_HALT    = 3'd5
    } op_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/seq_ctrl_ret_stack.sv
// Return-address stack: LIFO of DEPTH entries, top is the most recent push.
module ret_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] top
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] cnt_q;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign top   = empty ? '0 : mem_q[AW'(cnt_q - CW'(1))];

    // Entry storage and occupancy; overflow/underflow requests are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[AW'(cnt_q)] <= din;
            cnt_q             <= cnt_q + CW'(1);
        end else if (pop && !empty) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// Instruction sequencer: fetch/exec control with PC strobes and a return stack.
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             instr_valid,
    input  logic [2:0]       op_kind,
    input  logic [PC_W-1:0]  imm_target,
    input  logic [PC_W-1:0]  prog_ct,
    input  logic             cond,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             pc_branch,
    output logic [PC_W-1:0]  pc_target,
    output logic             pc_halt,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    seq_state_e      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] retired_q;

    logic            push, pop, stk_full, stk_empty, retire;
    logic [PC_W-1:0] stk_top;

    ret_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (prog_ct + PC_W'(1)),
        .full  (stk_full),
        .empty (stk_empty),
        .top   (stk_top)
    );

    // Next-state and PC strobe decode; strobes fire only in an unstalled EXEC.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tgt_d     = tgt_q;
        pc_en     = 1'b0;
        pc_branch = 1'b0;
        pc_target = '0;
        pc_halt   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    op_d    = op_kind;
                    tgt_d   = imm_target;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!mem_busy) begin
                    state_d = ST_FETCH;
                    case (op_q)
                        OP_SEQ: begin
                            pc_en = 1'b1;
                        end
                        OP_BR_COND: begin
                            pc_en     = 1'b1;
                            pc_branch = cond;
                            pc_target = tgt_q;
                        end
                        OP_JUMP: begin
                            pc_en     = 1'b1;
                            pc_branch = 1'b1;
                            pc_target = tgt_q;
                        end
                        OP_CALL: begin
                            if (stk_full) begin
                                state_d = ST_FAULT;
                            end else begin
                                push      = 1'b1;
                                pc_en     = 1'b1;
                                pc_branch = 1'b1;
                                pc_target = tgt_q;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                state_d = ST_FAULT;
                            end else begin
                                pop       = 1'b1;
                                pc_en     = 1'b1;
                                pc_branch = 1'b1;
                                pc_target = stk_top;
                            end
                        end
                        OP_HALT: begin
                            pc_halt = 1'b1;
                            state_d = ST_HALTED;
                        end
                        default: begin
                            state_d = ST_FAULT;
                        end
                    endcase
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    assign retire  = pc_en | pc_halt;
    assign busy    = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign done    = (state_q == ST_HALTED);
    assign fault   = (state_q == ST_FAULT);
    assign retired = retired_q;

    // State, latched op and saturating retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            tgt_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tgt_q   <= tgt_d;
            if (retire && (retired_q != '1)) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl with hand-computed expectations.
module tb_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        instr_valid;
    logic [2:0]  op_kind;
    logic [11:0] imm_target;
    logic [11:0] prog_ct;
    logic        cond;
    logic        mem_busy;
    logic        pc_en;
    logic        pc_branch;
    logic [11:0] pc_target;
    logic        pc_halt;
    logic        busy;
    logic        done;
    logic        fault;
    logic [15:0] retired;

    int checks   = 0;
    int failures = 0;

    logic        o_en, o_br, o_halt;
    logic [11:0] o_tgt;

    seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr_valid (instr_valid),
        .op_kind     (op_kind),
        .imm_target  (imm_target),
        .prog_ct     (prog_ct),
        .cond        (cond),
        .mem_busy    (mem_busy),
        .pc_en       (pc_en),
        .pc_branch   (pc_branch),
        .pc_target   (pc_target),
        .pc_halt     (pc_halt),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset mid-cycle, then start the sequencer into FETCH.
    task automatic restart();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Accept one instruction, execute it unstalled, capture the EXEC strobes.
    task automatic run_op(input logic [2:0] op, input logic [11:0] imm,
                          input logic [11:0] pc, input logic c);
        instr_valid = 1'b1;
        op_kind     = op;
        imm_target  = imm;
        tick();
        instr_valid = 1'b0;
        prog_ct     = pc;
        cond        = c;
        mem_busy    = 1'b0;
        #1;
        o_en   = pc_en;
        o_br   = pc_branch;
        o_tgt  = pc_target;
        o_halt = pc_halt;
        tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; instr_valid = 1'b0; op_kind = '0;
        imm_target = '0; prog_ct = '0; cond = 1'b0; mem_busy = 1'b0;
        #12;
        check_val("rst_pc_en", 32'(pc_en), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_retired", 32'(retired), 0);
        reset = 1'b1;
        tick();
        check_val("idle_busy", 32'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("fetch_busy", 32'(busy), 1);

        run_op(3'd0, 12'h000, 12'h010, 1'b0);
        check_val("seq_en", 32'(o_en), 1);
        check_val("seq_br", 32'(o_br), 0);
        check_val("seq_retired", 32'(retired), 1);
        check_val("seq_next_fetch_en", 32'(pc_en), 0);

        run_op(3'd1, 12'h200, 12'h011, 1'b1);
        check_val("br1_en", 32'(o_en), 1);
        check_val("br1_br", 32'(o_br), 1);
        check_val("br1_tgt", 32'(o_tgt), 32'h200);
        run_op(3'd1, 12'h200, 12'h012, 1'b0);
        check_val("br0_en", 32'(o_en), 1);
        check_val("br0_br", 32'(o_br), 0);

        run_op(3'd2, 12'h123, 12'h013, 1'b0);
        check_val("jmp_br", 32'(o_br), 1);
        check_val("jmp_tgt", 32'(o_tgt), 32'h123);

        run_op(3'd3, 12'h300, 12'h0FF, 1'b0);
        check_val("call_br", 32'(o_br), 1);
        check_val("call_tgt", 32'(o_tgt), 32'h300);
        run_op(3'd4, 12'h000, 12'h300, 1'b0);
        check_val("ret_en", 32'(o_en), 1);
        check_val("ret_tgt", 32'(o_tgt), 32'h100);
        run_op(3'd3, 12'h050, 12'hFFF, 1'b0);
        check_val("callwrap_tgt", 32'(o_tgt), 32'h050);
        run_op(3'd4, 12'h000, 12'h050, 1'b0);
        check_val("retwrap_en", 32'(o_en), 1);
        check_val("retwrap_tgt", 32'(o_tgt), 32'h000);
        check_val("retired_8", 32'(retired), 8);

        for (int i = 0; i < 4; i++) begin
            run_op(3'd3, 12'h400, 12'(i), 1'b0);
            check_val("call_fill_en", 32'(o_en), 1);
        end
        run_op(3'd3, 12'h400, 12'h004, 1'b0);
        check_val("call_ovf_en", 32'(o_en), 0);
        check_val("call_ovf_fault", 32'(fault), 1);
        check_val("call_ovf_busy", 32'(busy), 0);

        restart();
        run_op(3'd4, 12'h000, 12'h000, 1'b0);
        check_val("ret_empty_en", 32'(o_en), 0);
        check_val("ret_empty_fault", 32'(fault), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("fault_terminal", 32'(fault), 1);

        restart();
        check_val("restart_retired", 32'(retired), 0);
        instr_valid = 1'b1; op_kind = 3'd0;
        tick();
        instr_valid = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("stall_en", 32'(pc_en), 0);
            check_val("stall_busy", 32'(busy), 1);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        check_val("stall_c4_en", 32'(pc_en), 1);
        tick();
        check_val("stall_retired", 32'(retired), 1);

        run_op(3'd5, 12'h000, 12'h020, 1'b0);
        check_val("halt_pulse", 32'(o_halt), 1);
        check_val("halt_en", 32'(o_en), 0);
        check_val("halt_done", 32'(done), 1);
        check_val("halt_pulse_gone", 32'(pc_halt), 0);
        check_val("halt_retired", 32'(retired), 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("halted_start_ign", 32'(done), 1);
        check_val("halted_busy", 32'(busy), 0);

        restart();
        run_op(3'd6, 12'h000, 12'h000, 1'b0);
        check_val("illegal_en", 32'(o_en), 0);
        check_val("illegal_fault", 32'(fault), 1);

        restart();
        run_op(3'd0, 12'h000, 12'h001, 1'b0);
        check_val("pre_rst_retired", 32'(retired), 1);
        instr_valid = 1'b1; op_kind = 3'd2; imm_target = 12'h777;
        tick();
        instr_valid = 1'b0;
        mem_busy = 1'b1;
        #1;
        check_val("pre_rst_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check_val("midrst_busy", 32'(busy), 0);
        check_val("midrst_retired", 32'(retired), 0);
        mem_busy = 1'b0;
        #1;
        check_val("midrst_en", 32'(pc_en), 0);
        check_val("midrst_tgt", 32'(pc_target), 0);
        reset = 1'b1;
        tick();
        tick();
        check_val("post_rst_idle", 32'(busy), 0);
        check_val("post_rst_en", 32'(pc_en), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
